// File: rtl/hello_pkg.sv
// Shared types and helpers for the HELLO rotation sequencer.
package hello_pkg;

   localparam int NUM_POS = 5;

   typedef logic [2:0] pos_t;

   localparam pos_t LAST_POS = pos_t'(NUM_POS - 1);

   // Modulo-5 step: dir=0 increments, dir=1 decrements.
   function automatic pos_t next_pos(pos_t p, logic dir);
      pos_t r;
      if (!dir) begin
         r = (p >= LAST_POS) ? '0 : p + 3'd1;
      end else begin
         r = (p == '0 || p > LAST_POS) ? LAST_POS : p - 3'd1;
      end
      return r;
   endfunction

   // True when an advance from p in direction dir wraps around.
   function automatic logic is_wrap(pos_t p, logic dir);
      return (!dir) ? (p == LAST_POS) : (p == '0);
   endfunction

   // Out-of-range load values collapse to index 0.
   function automatic pos_t clamp_load(pos_t v);
      return (v <= LAST_POS) ? v : '0;
   endfunction

endpackage

// File: rtl/hello_scroll_ctrl_if.sv
// Control/status bundle between the sequencer and its driver.
// Signal semantics: run/dir/step_n are levels, load is a single-cycle
// strobe qualifying load_val, and tick/wrap are single-cycle pulses that
// coincide with the cycle in which pos shows its new value. There is no
// back-pressure: pos is always valid after reset.
interface hello_scroll_ctrl_if;
   import hello_pkg::*;

   logic run;
   logic dir;
   logic step_n;
   logic load;
   pos_t load_val;
   pos_t pos;
   logic tick;
   logic wrap;

   modport master (
      output run, dir, step_n, load, load_val,
      input  pos, tick, wrap
   );

   modport slave (
      input  run, dir, step_n, load, load_val,
      output pos, tick, wrap
   );

endinterface

// File: rtl/sync_fall_edge.sv
// Three-flop synchronizer with falling-edge detect; idles high.
module sync_fall_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic fall
);

   logic s1, s2, s3;

   // Shift the asynchronous input through the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // One request per high-to-low transition of the synchronized input.
   assign fall = s3 & ~s2;

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Rotation index sequencer for the HELLO display: prescaled auto-advance,
// pushbutton single-step and synchronous load, index kept in 0..4.
module hello_scroll_ctrl
   import hello_pkg::*;
#(
   parameter int TICKS_PER_STEP = 50_000_000,
   parameter int CNT_W          = 26
) (
   input  logic          CLOCK_50,
   input  logic          resetn,
   hello_scroll_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_STEP - 1);

   logic [CNT_W-1:0] cnt_q;
   pos_t             pos_q;
   logic             tick_q;
   logic             wrap_q;
   logic             adv_tick;
   logic             adv_step;
   logic             adv;

   sync_fall_edge u_step_sync (
      .clk   (CLOCK_50),
      .rst_n (resetn),
      .d     (bus.step_n),
      .fall  (adv_step)
   );

   // Terminal count only matters while running; load overrides below.
   assign adv_tick = bus.run & (cnt_q == TERM);
   assign adv      = adv_tick | adv_step;

   // Prescaler: holds while paused so a resume finishes the partial period.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (bus.load) begin
         cnt_q <= '0;
      end else if (bus.run) begin
         cnt_q <= adv_tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   // Index register with load priority; simultaneous requests advance once.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         pos_q  <= '0;
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else if (bus.load) begin
         pos_q  <= clamp_load(bus.load_val);
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         tick_q <= adv_tick;
         wrap_q <= adv & is_wrap(pos_q, bus.dir);
         if (adv) begin
            pos_q <= next_pos(pos_q, bus.dir);
         end
      end
   end

   assign bus.pos  = pos_q;
   assign bus.tick = tick_q;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Directed bench for hello_scroll_ctrl with a 4-cycle step period.
module tb_hello_scroll_ctrl;

   logic CLOCK_50;
   logic resetn;
   int   errors;
   int   checks;
   int   tick_cnt;
   int   wrap_cnt;

   hello_scroll_ctrl_if bus ();

   hello_scroll_ctrl #(
      .TICKS_PER_STEP (4),
      .CNT_W          (3)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .bus      (bus)
   );

   // Clock
   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int p, input int t, input int w);
      chk({tag, ".pos"},  int'(bus.pos),  p);
      chk({tag, ".tick"}, int'(bus.tick), t);
      chk({tag, ".wrap"}, int'(bus.wrap), w);
   endtask

   task automatic cyc();
      @(negedge CLOCK_50);
   endtask

   initial begin
      errors       = 0;
      checks       = 0;
      tick_cnt     = 0;
      wrap_cnt     = 0;
      resetn       = 1'b0;
      bus.run      = 1'b0;
      bus.dir      = 1'b0;
      bus.step_n   = 1'b1;
      bus.load     = 1'b0;
      bus.load_val = 3'd0;

      // Reset state
      cyc();
      cyc();
      chk_out("reset", 0, 0, 0);

      // Auto increment: pos changes every 4th edge, wraps once at 4->0
      resetn  = 1'b1;
      bus.run = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         cyc();
         chk_out($sformatf("inc_e%0d", k), (k / 4) % 5, (k % 4 == 0) ? 1 : 0, (k == 20) ? 1 : 0);
         tick_cnt += int'(bus.tick);
         wrap_cnt += int'(bus.wrap);
      end
      chk("inc_tick_count", tick_cnt, 6);
      chk("inc_wrap_count", wrap_cnt, 1);

      // Decrement from 0: 4 (with wrap), 3, 2, 1
      bus.run      = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 3'd0;
      cyc();
      chk_out("dec_load0", 0, 0, 0);
      bus.load = 1'b0;
      bus.dir  = 1'b1;
      bus.run  = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         chk_out($sformatf("dec_e%0d", k), (5 - (k / 4)) % 5, (k % 4 == 0) ? 1 : 0, (k == 4) ? 1 : 0);
      end

      // Pause after two counts, resume finishes the period in two edges
      bus.run      = 1'b0;
      bus.dir      = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 3'd0;
      cyc();
      bus.load = 1'b0;
      bus.run  = 1'b1;
      cyc();
      cyc();
      chk_out("pause_pre", 0, 0, 0);
      bus.run = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         chk_out($sformatf("pause_e%0d", k), 0, 0, 0);
      end
      bus.run = 1'b1;
      cyc();
      chk_out("resume_e1", 0, 0, 0);
      cyc();
      chk_out("resume_e2", 1, 1, 0);
      bus.run = 1'b0;

      // Single step: one increment on edge 3 after the first low sample
      bus.step_n = 1'b0;
      cyc();
      chk_out("step_e1", 1, 0, 0);
      cyc();
      chk_out("step_e2", 1, 0, 0);
      cyc();
      chk_out("step_e3", 2, 0, 0);
      for (int k = 4; k <= 7; k++) begin
         cyc();
         chk_out($sformatf("step_hold_e%0d", k), 2, 0, 0);
      end
      bus.step_n = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk_out($sformatf("step_rel_e%0d", k), 2, 0, 0);
      end

      // Load beats a due terminal count at pos 4: no tick, no wrap
      bus.load     = 1'b1;
      bus.load_val = 3'd4;
      cyc();
      chk_out("load4", 4, 0, 0);
      bus.load = 1'b0;
      bus.run  = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk_out($sformatf("load_pre_e%0d", k), 4, 0, 0);
      end
      bus.load     = 1'b1;
      bus.load_val = 3'd6;
      cyc();
      chk_out("load6", 0, 0, 0);
      bus.load_val = 3'd3;
      cyc();
      chk_out("load3", 3, 0, 0);
      bus.load = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         cyc();
         chk_out($sformatf("load_post_e%0d", k), 3, 0, 0);
      end
      cyc();
      chk_out("load_post_e4", 4, 1, 0);

      // Step edge coincident with terminal count: single advance
      bus.run      = 1'b0;
      bus.load     = 1'b1;
      bus.load_val = 3'd0;
      cyc();
      bus.load = 1'b0;
      bus.run  = 1'b1;
      cyc();
      bus.step_n = 1'b0;
      cyc();
      chk_out("coin_e2", 0, 0, 0);
      cyc();
      chk_out("coin_e3", 0, 0, 0);
      cyc();
      chk_out("coin_e4", 1, 1, 0);
      cyc();
      chk_out("coin_e5", 1, 0, 0);
      bus.step_n = 1'b1;
      cyc();
      cyc();
      bus.step_n = 1'b0;
      cyc();
      chk_out("coin_e8", 2, 1, 0);

      // Async reset mid-pulse clears outputs and pending step edge
      resetn     = 1'b0;
      bus.step_n = 1'b1;
      #1;
      chk_out("areset", 0, 0, 0);
      bus.run = 1'b0;
      cyc();
      cyc();
      resetn = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk_out($sformatf("post_rst_e%0d", k), 0, 0, 0);
      end
      bus.run = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         chk_out($sformatf("rerun_e%0d", k), (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
